// File: rtl/lut_mult_pkg.sv
// Shared types and constants for the nibble-serial LUT multiplier sequencer.
// Holds the sequencer state encoding and the LUT interface widths.
package lut_mult_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int LUT_RES_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index width for a counter over n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_mult_accum.sv
// Shift-accumulator for the LUT multiplier sequencer.
// Adds a zero-extended 8-bit partial product, shifted left by shift_amt bits,
// into a 2*WIDTH-bit running sum. The sum is sized so it never wraps.
module lut_mult_accum
    import lut_mult_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int SH_W  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 add_en,
    input  logic [LUT_RES_W-1:0] lut_result,
    input  logic [SH_W-1:0]      shift_amt,
    output logic [ACC_W-1:0]     acc
);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] addend;

    assign addend = ACC_W'(lut_result) << shift_amt;

    // Running sum: clear on a new operation, add one aligned partial product when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (add_en) begin
            acc_reg <= acc_reg + addend;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/lut_mult_seq_ctrl.sv
// Nibble-serial WIDTH x WIDTH unsigned multiplier sequencer.
// Walks every (op_a nibble i, op_b nibble j) pair, i inner and j outer, drives
// the pair onto the shared 4x4 LUT, waits LUT_LATENCY cycles and accumulates
// the 8-bit partial product shifted by 4*(i+j).
// Optional build macro: LUT_MULT_ZERO_SKIP_EN -- pairs with a zero nibble are
// skipped in a single ISSUE cycle without touching the LUT sources.
// Timing note: the LUT sources are loaded on the edge that enters ISSUE, so they
// are already stable during the ISSUE cycle and lut_result is valid in the last
// WAIT cycle for any LUT_LATENCY in 1..4.
module lut_mult_seq_ctrl
    import lut_mult_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int LUT_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [NIBBLE_W-1:0]  lut_src_0,
    output logic [NIBBLE_W-1:0]  lut_src_1,
    input  logic [LUT_RES_W-1:0] lut_result
);

    localparam int N      = WIDTH / NIBBLE_W;
    localparam int ACC_W  = 2 * WIDTH;
    localparam int IDX_W  = idx_width(N);
    localparam int SH_W   = IDX_W + 3;
    localparam int WAIT_W = 3;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
    localparam logic [WAIT_W-1:0] LAT_LOAD = WAIT_W'(LUT_LATENCY);

    state_t              state_reg, state_next;
    logic [WIDTH-1:0]    a_reg, a_next;
    logic [WIDTH-1:0]    b_reg, b_next;
    logic [IDX_W-1:0]    i_reg, i_next;
    logic [IDX_W-1:0]    j_reg, j_next;
    logic [WAIT_W-1:0]   wait_reg, wait_next;
    logic [IDX_W-1:0]    i_adv, j_adv;
    logic                last_pair;
    logic                pair_skip;
    logic                enter_issue;
    logic                load_src;
    logic                acc_clear;
    logic                acc_add;
    logic [SH_W-1:0]     shift_amt;
    logic [ACC_W-1:0]    acc;
    logic [NIBBLE_W-1:0] src0_reg, src1_reg;
    logic [NIBBLE_W-1:0] src0_sel, src1_sel;
    logic [ACC_W-1:0]    product_reg;

    // Nibble views of the operands that will be in force after this edge.
    logic [NIBBLE_W-1:0] a_nxt_nib [N];
    logic [NIBBLE_W-1:0] b_nxt_nib [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_nxt_nib
            assign a_nxt_nib[gi] = a_next[gi*NIBBLE_W +: NIBBLE_W];
            assign b_nxt_nib[gi] = b_next[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

`ifdef LUT_MULT_ZERO_SKIP_EN
    // Nibble views of the captured operands, used to decide skips in ISSUE.
    logic [NIBBLE_W-1:0] a_cur_nib [N];
    logic [NIBBLE_W-1:0] b_cur_nib [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cur_nib
            assign a_cur_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
            assign b_cur_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    assign pair_skip = (a_cur_nib[i_reg] == '0) || (b_cur_nib[j_reg] == '0);
`else
    assign pair_skip = 1'b0;
`endif

    // Pair bookkeeping: i is the inner index, j increments when i wraps.
    assign last_pair = (i_reg == LAST_IDX) && (j_reg == LAST_IDX);
    assign i_adv     = (i_reg == LAST_IDX) ? '0 : i_reg + 1'b1;
    assign j_adv     = (i_reg == LAST_IDX) ? j_reg + 1'b1 : j_reg;
    assign shift_amt = {({1'b0, i_reg} + {1'b0, j_reg}), 2'b00};

    // State, operand, index and wait-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            wait_reg  <= wait_next;
        end
    end

    // Next-state logic: accept in IDLE, issue a pair, wait out the LUT, accumulate.
    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        i_next      = i_reg;
        j_next      = j_reg;
        wait_next   = wait_reg;
        acc_clear   = 1'b0;
        acc_add     = 1'b0;
        enter_issue = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next      = op_a;
                    b_next      = op_b;
                    i_next      = '0;
                    j_next      = '0;
                    acc_clear   = 1'b1;
                    enter_issue = 1'b1;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                if (pair_skip) begin
                    if (last_pair) begin
                        state_next = DONE;
                    end else begin
                        i_next      = i_adv;
                        j_next      = j_adv;
                        enter_issue = 1'b1;
                        state_next  = ISSUE;
                    end
                end else begin
                    wait_next  = LAT_LOAD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_reg == WAIT_W'(1)) begin
                    acc_add = 1'b1;
                    if (last_pair) begin
                        state_next = DONE;
                    end else begin
                        i_next      = i_adv;
                        j_next      = j_adv;
                        enter_issue = 1'b1;
                        state_next  = ISSUE;
                    end
                end else begin
                    wait_next = wait_reg - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Select the nibbles for the pair about to be issued; skipped pairs leave the sources alone.
    always_comb begin
        src0_sel = a_nxt_nib[i_next];
        src1_sel = b_nxt_nib[j_next];
`ifdef LUT_MULT_ZERO_SKIP_EN
        load_src = enter_issue && (src0_sel != '0) && (src1_sel != '0);
`else
        load_src = enter_issue;
`endif
    end

    // LUT source registers: updated only when a pair is issued, otherwise held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src0_reg <= '0;
            src1_reg <= '0;
        end else if (load_src) begin
            src0_reg <= src0_sel;
            src1_reg <= src1_sel;
        end
    end

    lut_mult_accum #(
        .ACC_W (ACC_W),
        .SH_W  (SH_W)
    ) u_accum (
        .clk        (clk),
        .reset      (reset),
        .clear      (acc_clear),
        .add_en     (acc_add),
        .lut_result (lut_result),
        .shift_amt  (shift_amt),
        .acc        (acc)
    );

    // Result register: latches the finished sum during DONE and holds it afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            product_reg <= '0;
        end else if (state_reg == DONE) begin
            product_reg <= acc;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign product   = done ? acc : product_reg;
    assign lut_src_0 = src0_reg;
    assign lut_src_1 = src1_reg;

endmodule

// File: tb/tb_lut_mult_seq_ctrl.sv
// Scoreboard bench for lut_mult_seq_ctrl with a delayed 4x4 LUT model.
// The driver pushes expected product/latency per accepted start; a monitor
// pops and compares whenever done is seen, and checks busy every cycle.
module tb_lut_mult_seq_ctrl;

    localparam int WIDTH   = 16;
    localparam int LUT_LAT = 1;
    localparam int N       = WIDTH / 4;
    localparam int P       = N * N;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [WIDTH-1:0]     op_a = '0;
    logic [WIDTH-1:0]     op_b = '0;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [3:0]           lut_src_0;
    logic [3:0]           lut_src_1;
    logic [7:0]           lut_result;

    always #5 clk = ~clk;

    lut_mult_seq_ctrl #(
        .WIDTH       (WIDTH),
        .LUT_LATENCY (LUT_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .lut_src_0  (lut_src_0),
        .lut_src_1  (lut_src_1),
        .lut_result (lut_result)
    );

    // Shared LUT model: product of the sources appears LUT_LAT cycles later.
    logic [7:0] lut_pipe [LUT_LAT];
    always @(posedge clk) begin
        lut_pipe[0] <= lut_src_0 * lut_src_1;
        for (int k = 1; k < LUT_LAT; k++) lut_pipe[k] <= lut_pipe[k-1];
    end
    assign lut_result = lut_pipe[LUT_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [63:0]      prod;
        int               c0;
        int               lat;
        int               zp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Number of (i, j) nibble pairs in which either nibble is zero.
    function automatic int zero_pairs(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int z = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (((a >> (4*i)) & 15) == 0 || ((b >> (4*j)) & 15) == 0) z++;
        return z;
    endfunction

    function automatic int exp_latency(input int z);
`ifdef LUT_MULT_ZERO_SKIP_EN
        return z + (P - z) * (LUT_LAT + 1) + 1;
`else
        return P * (LUT_LAT + 1) + 1 + 0 * z;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] rnd_operand();
        logic [WIDTH-1:0] v;
        v = WIDTH'($urandom);
        for (int k = 0; k < N; k++)
            if ($urandom_range(0, 3) == 0) v[4*k +: 4] = 4'h0;
        return v;
    endfunction

    // Monitor: sample just after each rising edge.
    initial begin : monitor
        exp_t       e;
        logic       exp_busy;
        logic       prev_busy = 1'b0;
        logic       prev_rst  = 1'b1;
        logic [3:0] prev_s0   = '0;
        logic [3:0] prev_s1   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                exp_busy = (sb_q.size() > 0) && (cyc > sb_q[0].c0) && (cyc <= sb_q[0].c0 + sb_q[0].lat);
                check("busy", 64'(busy), 64'(exp_busy));
                if (done) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected at cycle %0d: got done=1, expected no pending operation", cyc);
                    end else begin
                        e = sb_q.pop_front();
                        check("product", 64'(product), e.prod);
                        check("latency", 64'(cyc - e.c0), 64'(e.lat));
                        $display("txn a=%h b=%h product=%h expected=%h cycles=%0d zero_pairs=%0d",
                                 e.a, e.b, product, e.prod, cyc - e.c0, e.zp);
                    end
                end
                if (!busy && !prev_busy && !prev_rst) begin
                    check("src_hold_idle", 64'({lut_src_0, lut_src_1}), 64'({prev_s0, prev_s1}));
                end
            end
            prev_busy = busy;
            prev_rst  = reset;
            prev_s0   = lut_src_0;
            prev_s1   = lut_src_1;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout at cycle %0d: got busy=%b, expected 0", cyc, busy);
        end
    endtask

    // Issue one operation; optionally poke ignored starts or reset part way through.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit poke, input int rst_at);
        exp_t e;
        int   c0;
        int   n;
        wait_idle();
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        c0    = cyc;
        e.a    = a;
        e.b    = b;
        e.prod = 64'(a) * 64'(b);
        e.c0   = c0;
        e.zp   = zero_pairs(a, b);
        e.lat  = exp_latency(e.zp);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op_a  = WIDTH'($urandom);
        op_b  = WIDTH'($urandom);
        if (rst_at > 0) begin
            while (cyc < c0 + rst_at) @(negedge clk);
            reset = 1'b1;
            sb_q.delete();
            #1;
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_done", 64'(done), 64'(0));
            check("rst_product", 64'(product), 64'(0));
            check("rst_src", 64'({lut_src_0, lut_src_1}), 64'(0));
            @(negedge clk);
            reset = 1'b0;
        end else if (poke) begin
            while (cyc < c0 + 5) @(negedge clk);
            op_a  = WIDTH'($urandom);
            op_b  = WIDTH'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (done !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (n >= 300) begin
                checks++;
                errors++;
                $display("FAIL done_timeout at cycle %0d: got done=%b, expected 1", cyc, done);
            end
            op_a  = WIDTH'($urandom);
            op_b  = WIDTH'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin : driver
        int n;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_product", 64'(product), 64'(0));
        check("reset_src", 64'({lut_src_0, lut_src_1}), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        run_op(16'h1234, 16'h5678, 1'b1, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
        run_op(16'h0000, 16'hBEEF, 1'b0, 0);
        run_op(16'h000F, 16'h000F, 1'b1, 0);
        run_op(16'h1234, 16'h5678, 1'b0, 10);
        run_op(16'hA5C3, 16'h0F1E, 1'b0, 0);
        for (int t = 0; t < 24; t++) begin
            run_op(rnd_operand(), rnd_operand(), ($urandom_range(0, 3) == 0), 0);
        end

        n = 0;
        while (sb_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb_q.size());
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
